// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage and EX/MEM pipeline register.
// Contents: ALUOp encodings, funct codes, bit positions inside the EX/M/WB
// control fields, forwarding select encoding and the multiply FSM states.
package ex_mem_stage_pkg;

  // ALUOp field values
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // R-type funct values (immediate bits [5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  // EX field: {RegDst, ALUSrc, ALUOp[1:0]}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 2;
  localparam int EX_ALUOP_HI = 1;
  localparam int EX_ALUOP_LO = 0;

  // M field: {MemRead, MemWrite}
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // WB field: {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Operand source: ID/EX data, EX/MEM result, or MEM/WB write value
  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Iterative multiply controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier producing the low DATA_W bits of a*b.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           a multiply is present in EX (level, held while busy)
//   abort           squash: return to IDLE, ignore start this cycle
//   a, b            operands, latched on the IDLE->BUSY transition
//   busy            stall request (IDLE with start, or BUSY)
//   done            product valid this cycle (state DONE)
//   product         accumulator, valid while done=1
//   state           FSM state for observation
// Handshake: the requester holds start high with stable operands; busy is
// high for DATA_W+1 cycles, then done is high for exactly one cycle, during
// which the consumer takes product. The FSM returns to IDLE after DONE and
// starts again only if start is still high there.
module ex_iter_mul
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic [1:0]        state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mul_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  // Only the low DATA_W product bits are kept, so the multiplicand can
  // simply shift left inside DATA_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (!abort) begin
      if (state_q == IDLE && start) begin
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == BUSY) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign product = acc_q;
  assign state   = state_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU, iterative multiply and the
// EX/MEM pipeline register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ID_EX_*                    operands, addresses, immediate and controls
//   MEM_WB_RegWrite/RdAddr/WriteData   writeback-stage forwarding source
//   ex_flush                   squash the instruction in EX
//   ex_stall                   hold PC, IF/ID and ID/EX (multiply running)
//   EX_MEM_*                   registered result, store data, destination,
//                              M/WB controls and zero flag
// Optional build macro ALU_OVF_TRAP_EN adds EX_MEM_Ovf: signed overflow on
// add/sub sets it and suppresses RegWrite for that instruction.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ID_EX_RsData,
  input  logic [DATA_W-1:0] ID_EX_RtData,
  input  logic [ADDR_W-1:0] ID_EX_RsAddr,
  input  logic [ADDR_W-1:0] ID_EX_RtAddr,
  input  logic [ADDR_W-1:0] ID_EX_RdAddr,
  input  logic [DATA_W-1:0] ID_EX_SignExtend,
  input  logic [3:0]        ID_EX_EX,
  input  logic [1:0]        ID_EX_M,
  input  logic [1:0]        ID_EX_WB,
  input  logic              MEM_WB_RegWrite,
  input  logic [ADDR_W-1:0] MEM_WB_RdAddr,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  input  logic              ex_flush,
  output logic              ex_stall,
  output logic [DATA_W-1:0] EX_MEM_AluResult,
  output logic [DATA_W-1:0] EX_MEM_WriteData,
  output logic [ADDR_W-1:0] EX_MEM_RdAddr,
  output logic [1:0]        EX_MEM_M,
  output logic [1:0]        EX_MEM_WB,
`ifdef ALU_OVF_TRAP_EN
  output logic              EX_MEM_Ovf,
`endif
  output logic              EX_MEM_Zero
);

  localparam int MSB = DATA_W - 1;

  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              is_rtype, is_mul;
  logic              exmem_fwd_ok, memwb_fwd_ok;
  fwd_sel_t          fwd_a, fwd_b;
  logic [DATA_W-1:0] op_a, rt_fwd, op_b;
  logic              slt_lt;
  logic [DATA_W-1:0] alu_out, result;
  logic [ADDR_W-1:0] dest;
  logic [1:0]        wb_next;
  logic              mul_busy, mul_done, bubble;
  logic [DATA_W-1:0] mul_product;
  logic [1:0]        mul_state;

  assign alu_op   = ID_EX_EX[EX_ALUOP_HI:EX_ALUOP_LO];
  assign funct    = ID_EX_SignExtend[5:0];
  assign is_rtype = (alu_op == ALUOP_RTYPE);
  assign is_mul   = is_rtype && (funct == FUNCT_MUL);

  // A stage only forwards if it actually writes a nonzero register.
  assign exmem_fwd_ok = EX_MEM_WB[WB_REGWRITE] && (EX_MEM_RdAddr != '0);
  assign memwb_fwd_ok = MEM_WB_RegWrite && (MEM_WB_RdAddr != '0);

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_a = FWD_ID;
    fwd_b = FWD_ID;
    if (exmem_fwd_ok && EX_MEM_RdAddr == ID_EX_RsAddr)      fwd_a = FWD_MEM;
    else if (memwb_fwd_ok && MEM_WB_RdAddr == ID_EX_RsAddr) fwd_a = FWD_WB;
    if (exmem_fwd_ok && EX_MEM_RdAddr == ID_EX_RtAddr)      fwd_b = FWD_MEM;
    else if (memwb_fwd_ok && MEM_WB_RdAddr == ID_EX_RtAddr) fwd_b = FWD_WB;
  end

  always_comb begin
    op_a = ID_EX_RsData;
    case (fwd_a)
      FWD_MEM: op_a = EX_MEM_AluResult;
      FWD_WB:  op_a = MEM_WB_WriteData;
      default: op_a = ID_EX_RsData;
    endcase
    rt_fwd = ID_EX_RtData;
    case (fwd_b)
      FWD_MEM: rt_fwd = EX_MEM_AluResult;
      FWD_WB:  rt_fwd = MEM_WB_WriteData;
      default: rt_fwd = ID_EX_RtData;
    endcase
  end

  assign op_b   = ID_EX_EX[EX_ALUSRC] ? ID_EX_SignExtend : rt_fwd;
  assign slt_lt = ($signed(op_a) < $signed(op_b));

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALUOP_ADD: alu_out = op_a + op_b;
      ALUOP_SUB: alu_out = op_a - op_b;
      ALUOP_AND: alu_out = op_a & op_b;
      default: begin
        case (funct)
          FUNCT_ADD: alu_out = op_a + op_b;
          FUNCT_SUB: alu_out = op_a - op_b;
          FUNCT_AND: alu_out = op_a & op_b;
          FUNCT_OR:  alu_out = op_a | op_b;
          FUNCT_SLT: alu_out = {{(DATA_W-1){1'b0}}, slt_lt};
          default:   alu_out = '0;
        endcase
      end
    endcase
  end

  // The multiplier always takes forwarded Rt, never the immediate.
  ex_iter_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (is_mul),
    .abort   (ex_flush),
    .a       (op_a),
    .b       (rt_fwd),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  assign ex_stall = mul_busy && !ex_flush;
  assign result   = mul_done ? mul_product : alu_out;
  assign dest     = ID_EX_EX[EX_REGDST] ? ID_EX_RdAddr : ID_EX_RtAddr;

  // A multiply only reaches EX/MEM from DONE; every other cycle it is a bubble.
  assign bubble = ex_flush || mul_busy || (is_mul && (mul_state != DONE));

`ifdef ALU_OVF_TRAP_EN
  logic is_add, is_sub, ovf;
  assign is_add = (alu_op == ALUOP_ADD) || (is_rtype && funct == FUNCT_ADD);
  assign is_sub = (alu_op == ALUOP_SUB) || (is_rtype && funct == FUNCT_SUB);
  assign ovf = is_add ? ((op_a[MSB] == op_b[MSB]) && (alu_out[MSB] != op_a[MSB])) :
               is_sub ? ((op_a[MSB] != op_b[MSB]) && (alu_out[MSB] != op_a[MSB])) :
               1'b0;
`endif

  always_comb begin
    wb_next = ID_EX_WB;
`ifdef ALU_OVF_TRAP_EN
    if (ovf) wb_next[WB_REGWRITE] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_AluResult <= '0;
      EX_MEM_WriteData <= '0;
      EX_MEM_RdAddr    <= '0;
      EX_MEM_M         <= '0;
      EX_MEM_WB        <= '0;
      EX_MEM_Zero      <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      EX_MEM_Ovf       <= 1'b0;
`endif
    end else if (bubble) begin
      EX_MEM_AluResult <= '0;
      EX_MEM_WriteData <= '0;
      EX_MEM_RdAddr    <= '0;
      EX_MEM_M         <= '0;
      EX_MEM_WB        <= '0;
      EX_MEM_Zero      <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      EX_MEM_Ovf       <= 1'b0;
`endif
    end else begin
      EX_MEM_AluResult <= result;
      EX_MEM_WriteData <= rt_fwd;
      EX_MEM_RdAddr    <= dest;
      EX_MEM_M         <= ID_EX_M;
      EX_MEM_WB        <= wb_next;
      EX_MEM_Zero      <= (result == '0);
`ifdef ALU_OVF_TRAP_EN
      EX_MEM_Ovf       <= ovf;
`endif
    end
  end

endmodule
